// File: rtl/cu_seq_if.sv
// cu_seq_if: ID-side instruction fields in, ID/EX control bundle out.
// master drives the instruction; slave is the control unit.
interface cu_seq_if #(
  parameter int REG_CNT   = 16,
  parameter int REG_IDX_W = $clog2(REG_CNT)
);
  logic                 valid_in;
  logic [1:0]           mode;
  logic [3:0]           op_code;
  logic                 S;
  logic                 imm;
  logic [REG_CNT-1:0]   reg_list;
  logic                 stall;
  logic                 flush;

  logic                 out_valid;
  logic [3:0]           exe_command;
  logic                 mem_read;
  logic                 mem_write;
  logic                 wb_enable;
  logic                 is_immediate;
  logic                 B;
  logic                 update_status;
  logic [REG_IDX_W-1:0] xfer_reg;
  logic [REG_IDX_W-1:0] xfer_offset;
  logic                 busy;

  modport master (
    output valid_in, mode, op_code, S, imm, reg_list, stall, flush,
    input  out_valid, exe_command, mem_read, mem_write, wb_enable,
           is_immediate, B, update_status, xfer_reg, xfer_offset, busy
  );

  modport slave (
    input  valid_in, mode, op_code, S, imm, reg_list, stall, flush,
    output out_valid, exe_command, mem_read, mem_write, wb_enable,
           is_immediate, B, update_status, xfer_reg, xfer_offset, busy
  );
endinterface

// File: rtl/cu_seq.sv
// cu_seq: ID decode control unit, registered ID/EX controls.
// CU_SEQ_BLOCK_XFER_EN enables the mode 3 load/store-multiple sequencer.
module cu_seq #(
  parameter int REG_CNT   = 16,
  parameter int REG_IDX_W = $clog2(REG_CNT)
) (
  input logic     clk,
  input logic     rst,
  cu_seq_if.slave bus
);

  typedef struct packed {
    logic                 ov;
    logic [3:0]           cmd;
    logic                 mr;
    logic                 mw;
    logic                 wb;
    logic                 imm;
    logic                 b;
    logic                 us;
    logic [REG_IDX_W-1:0] xr;
    logic [REG_IDX_W-1:0] xo;
  } ctl_t;

  ctl_t ctl_q, ctl_d, dec;

  always_comb begin
    dec    = '0;
    dec.ov = 1'b1;
    unique case (bus.mode)
      2'd0: begin
        dec.imm = bus.imm;
        dec.us  = bus.S;
        dec.wb  = 1'b1;
        case (bus.op_code)
          4'b1101: dec.cmd = 4'b0001;
          4'b1111: dec.cmd = 4'b1001;
          4'b0100: dec.cmd = 4'b0010;
          4'b0101: dec.cmd = 4'b0011;
          4'b0010: dec.cmd = 4'b0100;
          4'b0110: dec.cmd = 4'b0101;
          4'b0000: dec.cmd = 4'b0110;
          4'b1100: dec.cmd = 4'b0111;
          4'b0001: dec.cmd = 4'b1000;
          4'b1010: begin
            dec.cmd = 4'b0100;
            dec.wb  = 1'b0;
            dec.us  = 1'b1;
          end
          4'b1000: begin
            dec.cmd = 4'b0110;
            dec.wb  = 1'b0;
            dec.us  = 1'b1;
          end
          default: dec.wb = 1'b0;
        endcase
      end
      2'd1: begin
        dec.imm = bus.imm;
        dec.cmd = 4'b0010;
        dec.mr  = bus.S;
        dec.wb  = bus.S;
        dec.mw  = ~bus.S;
      end
      2'd2: dec.b = 1'b1;
      default: ;
    endcase
  end

`ifdef CU_SEQ_BLOCK_XFER_EN
  typedef enum logic {IDLE, XFER} state_e;

  localparam logic [REG_CNT-1:0] ONE = REG_CNT'(1);

  state_e             state_q, state_d;
  logic [REG_CNT-1:0] rem_q, rem_d;
  logic               dir_q, dir_d;
  logic [REG_CNT-1:0] sel;
  logic               dirn;
  ctl_t               beat;

  function automatic logic [REG_IDX_W-1:0] lsb_idx(
    input logic [REG_CNT-1:0] v
  );
    lsb_idx = '0;
    for (int i = REG_CNT - 1; i >= 0; i--)
      if (v[i]) lsb_idx = REG_IDX_W'(i);
  endfunction

  // First beat comes straight from the list; later ones from remaining.
  always_comb begin
    sel     = (state_q == IDLE) ? bus.reg_list : rem_q;
    dirn    = (state_q == IDLE) ? bus.S : dir_q;
    beat    = '0;
    beat.ov = 1'b1;
    beat.cmd = 4'b0010;
    beat.mr = dirn;
    beat.wb = dirn;
    beat.mw = ~dirn;
    beat.xr = lsb_idx(sel);
    beat.xo = (state_q == IDLE) ? '0 : ctl_q.xo + REG_IDX_W'(1);
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    ctl_d   = ctl_q;
    if (bus.flush) begin
      state_d = IDLE;
      rem_d   = '0;
      ctl_d   = '0;
    end else if (!bus.stall) begin
      unique case (state_q)
        IDLE: begin
          ctl_d = '0;
          if (bus.valid_in) begin
            if (bus.mode == 2'b11 && |bus.reg_list) begin
              ctl_d = beat;
              rem_d = bus.reg_list & (bus.reg_list - ONE);
              dir_d = bus.S;
              if (|rem_d) state_d = XFER;
            end else begin
              ctl_d = dec;
            end
          end
        end
        XFER: begin
          ctl_d = beat;
          rem_d = rem_q & (rem_q - ONE);
          if (rem_d == '0) state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      ctl_q   <= ctl_d;
    end
  end

  assign bus.busy = (state_q == XFER);
`else
  logic unused_reg_list;
  assign unused_reg_list = ^bus.reg_list;

  always_comb begin
    ctl_d = ctl_q;
    if (bus.flush)
      ctl_d = '0;
    else if (!bus.stall)
      ctl_d = bus.valid_in ? dec : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) ctl_q <= '0;
    else     ctl_q <= ctl_d;
  end

  assign bus.busy = 1'b0;
`endif

  assign bus.out_valid     = ctl_q.ov;
  assign bus.exe_command   = ctl_q.cmd;
  assign bus.mem_read      = ctl_q.mr;
  assign bus.mem_write     = ctl_q.mw;
  assign bus.wb_enable     = ctl_q.wb;
  assign bus.is_immediate  = ctl_q.imm;
  assign bus.B             = ctl_q.b;
  assign bus.update_status = ctl_q.us;
  assign bus.xfer_reg      = ctl_q.xr;
  assign bus.xfer_offset   = ctl_q.xo;

endmodule

// File: tb/tb_cu_seq.sv
// tb_cu_seq: directed vectors for cu_seq with a queued scoreboard.
// Block-transfer vectors depend on CU_SEQ_BLOCK_XFER_EN.
module tb_cu_seq;
  localparam int RC = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cu_seq_if #(.REG_CNT(RC)) bus ();

  cu_seq #(.REG_CNT(RC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic          ov;
    logic [3:0]    cmd;
    logic          mr;
    logic          mw;
    logic          wb;
    logic          imm;
    logic          b;
    logic          us;
    logic [IW-1:0] xr;
    logic [IW-1:0] xo;
    logic          busy;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  localparam exp_t Z = '0;

  function automatic exp_t ex(
    input logic ov, input logic [3:0] cmd, input logic mr,
    input logic mw, input logic wb, input logic imm,
    input logic b, input logic us
  );
    exp_t e;
    e     = '0;
    e.ov  = ov;
    e.cmd = cmd;
    e.mr  = mr;
    e.mw  = mw;
    e.wb  = wb;
    e.imm = imm;
    e.b   = b;
    e.us  = us;
    return e;
  endfunction

  function automatic exp_t bt(
    input logic ld, input int r, input int o, input logic bsy
  );
    exp_t e;
    e      = ex(1'b1, 4'b0010, ld, ~ld, ld, 1'b0, 1'b0, 1'b0);
    e.xr   = IW'(r);
    e.xo   = IW'(o);
    e.busy = bsy;
    return e;
  endfunction

  task automatic drive(
    input logic v, input logic [1:0] m, input logic [3:0] op,
    input logic s, input logic im, input logic [RC-1:0] rl,
    input logic st, input logic fl, input logic r,
    input exp_t e, input string nm
  );
    bus.valid_in = v;
    bus.mode     = m;
    bus.op_code  = op;
    bus.S        = s;
    bus.imm      = im;
    bus.reg_list = rl;
    bus.stall    = st;
    bus.flush    = fl;
    rst          = r;
    @(posedge clk);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(negedge clk);
  endtask

  task automatic ins(
    input logic [1:0] m, input logic [3:0] op, input logic s,
    input logic im, input logic [RC-1:0] rl,
    input exp_t e, input string nm
  );
    drive(1'b1, m, op, s, im, rl, 1'b0, 1'b0, 1'b0, e, nm);
  endtask

  task automatic idle(input exp_t e, input string nm);
    drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, e, nm);
  endtask

  exp_t  m_e;
  exp_t  m_a;
  string m_n;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      m_n = nm_q.pop_front();
      m_a = {bus.out_valid, bus.exe_command, bus.mem_read,
             bus.mem_write, bus.wb_enable, bus.is_immediate,
             bus.B, bus.update_status, bus.xfer_reg,
             bus.xfer_offset, bus.busy};
      n_vec++;
      if (m_a !== m_e) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", m_n, m_a, m_e);
      end
    end
  end

  localparam exp_t BR = '{ov: 1'b1, b: 1'b1, default: '0};

  initial begin
    rst          = 1'b1;
    bus.valid_in = 1'b0;
    bus.mode     = '0;
    bus.op_code  = '0;
    bus.S        = 1'b0;
    bus.imm      = 1'b0;
    bus.reg_list = '0;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    @(negedge clk);

    drive(1, 0, 4'b0100, 1, 1, '0, 0, 0, 1, Z, "reset0");
    drive(0, 0, 4'b0000, 0, 0, '0, 0, 0, 1, Z, "reset1");

    ins(0, 4'b0100, 1, 1, '0,
        ex(1, 4'b0010, 0, 0, 1, 1, 0, 1), "add");
    ins(0, 4'b1010, 0, 0, '0,
        ex(1, 4'b0100, 0, 0, 0, 0, 0, 1), "cmp");
    ins(0, 4'b1000, 0, 1, '0,
        ex(1, 4'b0110, 0, 0, 0, 1, 0, 1), "tst");
    ins(0, 4'b1101, 0, 0, '0,
        ex(1, 4'b0001, 0, 0, 1, 0, 0, 0), "mov");
    ins(0, 4'b0001, 1, 0, '0,
        ex(1, 4'b1000, 0, 0, 1, 0, 0, 1), "eor");
    ins(0, 4'b0011, 1, 0, '0,
        ex(1, 4'b0000, 0, 0, 0, 0, 0, 1), "bad_op");
    ins(1, 4'b0000, 1, 0, '0,
        ex(1, 4'b0010, 1, 0, 1, 0, 0, 0), "ldr");
    ins(1, 4'b0000, 0, 0, '0,
        ex(1, 4'b0010, 0, 1, 0, 0, 0, 0), "str");
    idle(Z, "idle");
    ins(2, 4'b0000, 0, 0, '0, BR, "branch");
    drive(1, 0, 4'b0100, 1, 1, '0, 1, 0, 0, BR, "stall_hold");
    drive(1, 0, 4'b0100, 1, 1, '0, 1, 1, 0, Z, "flush_stall");
    idle(Z, "idle_after_flush");

`ifdef CU_SEQ_BLOCK_XFER_EN
    ins(3, 0, 1, 0, 16'h0092, bt(1, 1, 0, 1), "lm_b0");
    ins(2, 0, 0, 0, '0, bt(1, 4, 1, 1), "lm_b1_ign");
    idle(bt(1, 7, 2, 0), "lm_b2");
    ins(0, 4'b0100, 0, 0, '0,
        ex(1, 4'b0010, 0, 0, 1, 0, 0, 0), "add_after_lm");
    idle(Z, "lm_done");

    ins(3, 0, 1, 0, 16'h0092, bt(1, 1, 0, 1), "st_b0");
    idle(bt(1, 4, 1, 1), "st_b1");
    drive(0, 0, 0, 0, 0, '0, 1, 0, 0, bt(1, 4, 1, 1), "st_hold0");
    drive(0, 0, 0, 0, 0, '0, 1, 0, 0, bt(1, 4, 1, 1), "st_hold1");
    idle(bt(1, 7, 2, 0), "st_b2");
    idle(Z, "st_done");

    ins(3, 0, 0, 0, 16'hFFFF, bt(0, 0, 0, 1), "sm_b0");
    idle(bt(0, 1, 1, 1), "sm_b1");
    drive(0, 0, 0, 0, 0, '0, 0, 1, 0, Z, "sm_flush");
    ins(2, 0, 0, 0, '0, BR, "br_after_flush");

    ins(3, 0, 1, 0, 16'hFFFF, bt(1, 0, 0, 1), "lm16_b0");
    for (int i = 1; i < 16; i++)
      idle(bt(1, i, i, (i < 15)), "lm16_bn");
    idle(Z, "lm16_done");

    ins(3, 0, 1, 0, 16'hFFFF, bt(1, 0, 0, 1), "rst_b0");
    idle(bt(1, 1, 1, 1), "rst_b1");
    drive(0, 0, 0, 0, 0, '0, 0, 0, 1, Z, "rst_mid");
    idle(Z, "post_rst");

    ins(3, 0, 1, 0, 16'h0000,
        ex(1, 4'b0000, 0, 0, 0, 0, 0, 0), "lm_empty");
    ins(3, 0, 0, 0, 16'h8000, bt(0, 15, 0, 0), "sm_single");
    ins(2, 0, 0, 0, '0, BR, "br_after_single");
`else
    ins(3, 0, 1, 0, 16'h0092,
        ex(1, 4'b0000, 0, 0, 0, 0, 0, 0), "m3_nop");
    idle(Z, "m3_nop_done");
    ins(3, 0, 0, 0, 16'hFFFF,
        ex(1, 4'b0000, 0, 0, 0, 0, 0, 0), "m3_nop_full");
    ins(2, 0, 0, 0, '0, BR, "br_after_m3");
`endif
    idle(Z, "final_idle");

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
